// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexes a 16-bit hex value onto a four-digit
// seven-segment display. It drives one nibble at a time to a downstream
// hex decoder and also drives the shared active-low anode and decimal-point
// lines.
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   value      in   16-bit hex value, digit 0 = value[3:0] (rightmost)
//   dp_mask    in   per-digit decimal point enable (1 = lit)
//   lzb        in   blank leading-zero digits
//   load       in   1-cycle strobe capturing value/dp_mask/lzb
//   nibble     out  current digit code to the decoder
//   an         out  active-low anode enables (one-hot-low or all off)
//   dp         out  active-low decimal point
//   frame_done out  pulse on the last cycle of digit 3
// The displayed value is double-buffered and only changes on frame
// boundaries. Each digit slot begins with an all-off gap to suppress ghosting.
module seg_scan_mux #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic [3:0]  dp_mask,
  input  logic        lzb,
  input  logic        load,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dig_q, dig_d;
  logic [15:0]      pend_val_q, pend_val_d;
  logic [3:0]       pend_dp_q, pend_dp_d;
  logic             pend_lzb_q, pend_lzb_d;
  logic             pend_flag_q, pend_flag_d;
  logic [15:0]      sh_val_q, sh_val_d;
  logic [3:0]       sh_dp_q, sh_dp_d;
  logic             sh_lzb_q, sh_lzb_d;

  logic cnt_last;
  logic blank;
  logic supp;

  assign cnt_last   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
  assign frame_done = cnt_last && (dig_q == 2'd3);
  assign blank      = (cnt_q < CNT_W'(BLANK_CYC));

  // A digit is suppressed when it and every digit to its left are zero.
  always_comb begin
    supp = 1'b0;
    case (dig_q)
      2'd1:    supp = (sh_val_q[15:4]  == 12'h000);
      2'd2:    supp = (sh_val_q[15:8]  == 8'h00);
      2'd3:    supp = (sh_val_q[15:12] == 4'h0);
      default: supp = 1'b0;
    endcase
    supp = supp && sh_lzb_q;
  end

  // Display outputs derive directly from the registered scan state.
  assign nibble = sh_val_q[{dig_q, 2'b00} +: 4];
  assign an     = (blank || supp) ? 4'b1111 : ~(4'b0001 << dig_q);
  assign dp     = (blank || supp) ? 1'b1 : ~sh_dp_q[dig_q];

  // Scan counters and the pending/shadow double buffer.
  always_comb begin
    cnt_d       = cnt_last ? '0 : cnt_q + CNT_W'(1);
    dig_d       = cnt_last ? dig_q + 2'd1 : dig_q;
    pend_val_d  = pend_val_q;
    pend_dp_d   = pend_dp_q;
    pend_lzb_d  = pend_lzb_q;
    pend_flag_d = pend_flag_q;
    sh_val_d    = sh_val_q;
    sh_dp_d     = sh_dp_q;
    sh_lzb_d    = sh_lzb_q;

    if (load && frame_done) begin
      // A load on the boundary cycle bypasses the pending stage.
      sh_val_d    = value;
      sh_dp_d     = dp_mask;
      sh_lzb_d    = lzb;
      pend_flag_d = 1'b0;
    end else if (load) begin
      pend_val_d  = value;
      pend_dp_d   = dp_mask;
      pend_lzb_d  = lzb;
      pend_flag_d = 1'b1;
    end else if (frame_done && pend_flag_q) begin
      sh_val_d    = pend_val_q;
      sh_dp_d     = pend_dp_q;
      sh_lzb_d    = pend_lzb_q;
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      dig_q       <= '0;
      pend_val_q  <= '0;
      pend_dp_q   <= '0;
      pend_lzb_q  <= 1'b0;
      pend_flag_q <= 1'b0;
      sh_val_q    <= '0;
      sh_dp_q     <= '0;
      sh_lzb_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      dig_q       <= dig_d;
      pend_val_q  <= pend_val_d;
      pend_dp_q   <= pend_dp_d;
      pend_lzb_q  <= pend_lzb_d;
      pend_flag_q <= pend_flag_d;
      sh_val_q    <= sh_val_d;
      sh_dp_q     <= sh_dp_d;
      sh_lzb_q    <= sh_lzb_d;
    end
  end

endmodule
